ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port data RAM (async read, write on posedge clk when wr_en)
//  between two requesters: port A (CPU core) and port B (loader/debug DMA).
//  Round-robin arbitration with a burst-hold limit; one access per clock once
//  granted. Sits between the requesters and the RAM's abus/dbus/wr_en pins.
//  Owns the tristate drive of the shared bidirectional data bus.
// PARAMETERS
//  AW        8  address width (RAM abus width)
//  DW        8  data width (RAM dbus width)
//  HOLD_MAX  4  max consecutive accesses by one owner while the other port waits (>=1)
// PORTS
//  clk        in   1   system clock, all state on posedge
//  rst        in   1   asynchronous, active-high reset
//  a_req      in   1   port A request; hold addr/we/wdata stable while high
//  a_we       in   1   port A write (1) / read (0)
//  a_addr     in   AW  port A address
//  a_wdata    in   DW  port A write data
//  a_gnt      out  1   port A owns RAM this cycle; access occurs when a_gnt & a_req
//  a_rdata    out  DW  port A read data, registered
//  a_rvalid   out  1   one-cycle pulse, a_rdata valid
//  b_*        -    -   identical set for port B (b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid)
//  ram_abus   out  AW  RAM address
//  ram_dbus   inout DW RAM data; driven only when ram_wr_en=1, else Z (RAM drives it)
//  ram_wr_en  out  1   RAM write enable
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, a/b_gnt=0, a/b_rvalid=0, a/b_rdata=0,
//   last-served=B (A wins first tie), hold count=0; ram_wr_en=0, ram_abus=0, ram_dbus=Z.
//  FSM states IDLE, OWN_A, OWN_B; gnt outputs are decoded from state (registered).
//  IDLE: if a_req & (~b_req | last==B) -> OWN_A; else if b_req -> OWN_B; else stay.
//  OWN_x, x_req=1: access this cycle; count++ ; last<=x.
//   if other_req & count==HOLD_MAX-1 -> OWN_other, count<=0 (no dead cycle).
//  OWN_x, x_req=0: no access; -> OWN_other if other_req, else IDLE; count<=0.
//  Latency: req seen at edge N -> gnt after edge N; access in cycle N..N+1;
//   read data captured at edge N+1 into x_rdata, x_rvalid=1 for exactly one cycle.
//  RAM drive (combinational from state + owner inputs): ram_abus=owner addr when
//   owner req high, else 0; ram_wr_en=owner req & owner we; ram_dbus=owner wdata when
//   ram_wr_en, else Z. Non-owner port gets no access and no rvalid.
//  Write commits at end of granted cycle; read-after-write to same address in the
//   next cycle returns the new data.
//  x_rdata holds its last value between pulses; writes never pulse rvalid.
//  Reset mid-write: ram_wr_en drops at once, so no write reaches the RAM unless
//   the clock edge precedes reset assertion.
//  HOLD_MAX=1 degenerates to strict alternation under contention.
// STRUCTURE
//  Shared package: state encoding localparams (IDLE/OWN_A/OWN_B), default AW/DW.
//  One sub-module: arb_rr2 (2-way round-robin pick from req pair + last-served bit).
//  Tristate, FSM, hold counter ($clog2(HOLD_MAX)+1 bits) and read regs stay in top.
// TESTING
//  1 rst=1 mid-cycle -> all gnt/rvalid/rdata 0, ram_wr_en 0, ram_abus 0, ram_dbus Z at once.
//  2 A alone: write 0x5A@0x10, then read 0x10 -> a_gnt 1 cycle after req; a_rvalid pulse, a_rdata=0x5A.
//  3 a_req and b_req rise together after reset -> A granted first; B granted on first switch.
//  4 Both held high, HOLD_MAX=4 -> gnt pattern AAAABBBBAAAA, no idle cycles, ram_wr_en only in owner writes.
//  5 B owner drops req, A idle -> IDLE next edge, ram_dbus Z, no rvalid; B re-req -> B granted.
//  6 rst asserted during A write to 0x20 (before edge) -> mem[0x20] unchanged on later read.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - shared types and defaults for the RAM arbiter
package ram_arbiter_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// rtl/ram_arbiter_arb_rr2.sv - two-way round-robin pick from a request pair
module arb_rr2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_b,
    output logic pick_a,
    output logic pick_b
);

    // A wins a tie only when B was the last port served
    assign pick_a = req_a & (~req_b | last_b);
    assign pick_b = req_b & ~pick_a;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin share of a single-port RAM between ports A and B
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int HOLD_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic [AW-1:0] ram_abus,
    inout  wire  [DW-1:0] ram_dbus,
    output logic          ram_wr_en
);

    localparam int CW = $clog2(HOLD_MAX) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          last_b, last_b_n;
    logic          pick_a, pick_b;

    logic          own_req;
    logic          own_we;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;

    arb_rr2 u_rr (
        .req_a  (a_req),
        .req_b  (b_req),
        .last_b (last_b),
        .pick_a (pick_a),
        .pick_b (pick_b)
    );

    assign a_gnt = (state == OWN_A);
    assign b_gnt = (state == OWN_B);

    always_comb begin
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        case (state)
            OWN_A: begin
                own_req   = a_req;
                own_we    = a_we;
                own_addr  = a_addr;
                own_wdata = a_wdata;
            end
            OWN_B: begin
                own_req   = b_req;
                own_we    = b_we;
                own_addr  = b_addr;
                own_wdata = b_wdata;
            end
            default: ;
        endcase
    end

    assign ram_abus  = own_req ? own_addr : '0;
    assign ram_wr_en = own_req & own_we;
    assign ram_dbus  = ram_wr_en ? own_wdata : {DW{1'bz}};

    // Count saturates so an uncontended owner yields after one more access
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        last_b_n = last_b;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (pick_a)      state_n = OWN_A;
                else if (pick_b) state_n = OWN_B;
            end
            OWN_A: begin
                if (a_req) begin
                    last_b_n = 1'b0;
                    if (b_req && cnt == CNT_LAST) begin
                        state_n = OWN_B;
                        cnt_n   = '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = b_req ? OWN_B : IDLE;
                end
            end
            OWN_B: begin
                if (b_req) begin
                    last_b_n = 1'b1;
                    if (a_req && cnt == CNT_LAST) begin
                        state_n = OWN_A;
                        cnt_n   = '0;
                    end else if (cnt != CNT_LAST) begin
                        cnt_n = cnt + 1'b1;
                    end
                end else begin
                    cnt_n   = '0;
                    state_n = a_req ? OWN_A : IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_b   <= 1'b1;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_b   <= last_b_n;
            a_rvalid <= a_gnt & a_req & ~a_we;
            b_rvalid <= b_gnt & b_req & ~b_we;
            if (a_gnt & a_req & ~a_we) a_rdata <= ram_dbus;
            if (b_gnt & b_req & ~b_we) b_rdata <= ram_dbus;
        end
    end

endmodule
